// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state type and constants for the instruction fetch unit
package fetch_pkg;
    typedef enum logic [1:0] {S_FETCH = 2'd0, S_VALID = 2'd1, S_ERR = 2'd2} fetch_state_e;
    localparam logic [31:0] WORD_BYTES       = 32'd4;
    localparam logic [31:0] PC_OFFSET        = 32'd8;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_timeout.sv
// fetch_timeout: counts stalled fetch cycles and flags when the budget is spent
module fetch_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = clear ? '0 : enable ? cnt_q + W'(1) : cnt_q;
    end
    always_ff @(posedge clk) begin
        cnt_q <= !reset ? '0 : cnt_d;
    end
    assign expired = cnt_q == W'(TIMEOUT - 1);
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetches one instruction at a time and holds it until the core retires it
module instr_fetch import fetch_pkg::*; #(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        PCSrc,
    input  logic [31:0] pc_target,
    output logic [31:0] PC,
    output logic [31:0] PCPlus8,
    output logic        fetch_err
);
    fetch_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d;
    logic req_q, req_d, valid_q, valid_d, err_q, err_d;
    logic fetch, accept, retire, expired;
    always_comb begin
        fetch   = state_q == S_FETCH;
        accept  = fetch & imem_ack;
        retire  = (state_q == S_VALID) & instr_ready;
        state_d = accept ? S_VALID : (fetch & expired) ? S_ERR : retire ? S_FETCH : state_q;
        instr_d = accept ? imem_rdata : instr_q;
        pc_d    = retire ? (PCSrc ? pc_target & ~32'h3 : pc_q + WORD_BYTES) : pc_q;
        req_d   = state_d == S_FETCH;
        valid_d = state_d == S_VALID;
        err_d   = state_d == S_ERR;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end
    fetch_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .enable (fetch & ~imem_ack),
        .expired(expired)
    );
    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign Instr       = instr_q;
    assign instr_valid = valid_q;
    assign PC          = pc_q;
    assign PCPlus8     = pc_q + PC_OFFSET;
    assign fetch_err   = err_q;
endmodule
